alu_control: RTL and testbench

ALU_CONTROL -- requirements
Module: alu_control

---
 rtl/alu_control.sv | 134 +++++++++++++
 tb/tb_alu_control.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_control.sv
// ALU operation decoder: maps ALUOp/funct3/funct7 to a 4-bit ALU code plus an
// illegal-encoding flag, registered once per clock with async active-low reset.
module alu_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [1:0] CLS_MEM    = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_RTYPE  = 2'b10;
    localparam logic [1:0] CLS_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic       f7_base;
    logic       f7_alt;
    logic [3:0] ctrl_next;
    logic       illegal_next;

    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);

    always_comb begin
        ctrl_next    = OP_ADD;
        illegal_next = 1'b0;
        case (ALUOp)
            CLS_MEM: begin
                ctrl_next = OP_ADD;
            end

            CLS_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctrl_next = OP_SUB;
                    3'b100, 3'b101: ctrl_next = OP_SLT;
                    3'b110, 3'b111: ctrl_next = OP_SLTU;
                    3'b010, 3'b011: begin
                        ctrl_next    = OP_SUB;
                        illegal_next = 1'b1;
                    end
                    default: begin
                        ctrl_next    = OP_ADD;
                        illegal_next = 1'b1;
                    end
                endcase
            end

            // R-type: only ADD/SUB and SRL/SRA accept the alternate funct7
            CLS_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (f7_base)     ctrl_next = OP_ADD;
                        else if (f7_alt) ctrl_next = OP_SUB;
                        else             illegal_next = 1'b1;
                    end
                    3'b101: begin
                        if (f7_base)     ctrl_next = OP_SRL;
                        else if (f7_alt) ctrl_next = OP_SRA;
                        else             illegal_next = 1'b1;
                    end
                    3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111: begin
                        if (f7_base) begin
                            case (funct3)
                                3'b001:  ctrl_next = OP_SLL;
                                3'b010:  ctrl_next = OP_SLT;
                                3'b011:  ctrl_next = OP_SLTU;
                                3'b100:  ctrl_next = OP_XOR;
                                3'b110:  ctrl_next = OP_OR;
                                default: ctrl_next = OP_AND;
                            endcase
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                    default: illegal_next = 1'b1;
                endcase
            end

            // I-type: funct7 is immediate bits except for the shift encodings
            CLS_ITYPE: begin
                case (funct3)
                    3'b000: ctrl_next = OP_ADD;
                    3'b010: ctrl_next = OP_SLT;
                    3'b011: ctrl_next = OP_SLTU;
                    3'b100: ctrl_next = OP_XOR;
                    3'b110: ctrl_next = OP_OR;
                    3'b111: ctrl_next = OP_AND;
                    3'b001: begin
                        if (f7_base) ctrl_next = OP_SLL;
                        else         illegal_next = 1'b1;
                    end
                    3'b101: begin
                        if (f7_base)     ctrl_next = OP_SRL;
                        else if (f7_alt) ctrl_next = OP_SRA;
                        else             illegal_next = 1'b1;
                    end
                    default: illegal_next = 1'b1;
                endcase
            end

            default: begin
                ctrl_next    = OP_ADD;
                illegal_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl <= OP_ADD;
            illegal  <= 1'b0;
        end else begin
            alu_ctrl <= ctrl_next;
            illegal  <= illegal_next;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Directed-vector bench for alu_control: reset behaviour, per-class decode,
// one-cycle latency, input hold between edges and asynchronous reset.
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_ctrl;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    alu_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] ctrl;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] ctrl, input logic ill);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.ctrl = ctrl; v.ill = ill;
        vecs.push_back(v);
    endtask

    logic [4:0] prev_exp;

    initial begin
        // ALUOp  funct3  funct7      ctrl     illegal
        add_vec(2'b00, 3'b010, 7'h00, 4'b0000, 1'b0);
        add_vec(2'b00, 3'b111, 7'h7f, 4'b0000, 1'b0);
        add_vec(2'b01, 3'b000, 7'h00, 4'b0001, 1'b0);
        add_vec(2'b01, 3'b001, 7'h00, 4'b0001, 1'b0);
        add_vec(2'b01, 3'b100, 7'h00, 4'b1000, 1'b0);
        add_vec(2'b01, 3'b101, 7'h7f, 4'b1000, 1'b0);
        add_vec(2'b01, 3'b110, 7'h00, 4'b1001, 1'b0);
        add_vec(2'b01, 3'b111, 7'h00, 4'b1001, 1'b0);
        add_vec(2'b01, 3'b011, 7'h00, 4'b0001, 1'b1);
        add_vec(2'b01, 3'b010, 7'h00, 4'b0001, 1'b1);
        add_vec(2'b10, 3'b000, 7'h00, 4'b0000, 1'b0);
        add_vec(2'b10, 3'b111, 7'h00, 4'b0010, 1'b0);
        add_vec(2'b10, 3'b110, 7'h00, 4'b0011, 1'b0);
        add_vec(2'b10, 3'b100, 7'h00, 4'b0100, 1'b0);
        add_vec(2'b10, 3'b001, 7'h00, 4'b0101, 1'b0);
        add_vec(2'b10, 3'b101, 7'h00, 4'b0110, 1'b0);
        add_vec(2'b10, 3'b010, 7'h00, 4'b1000, 1'b0);
        add_vec(2'b10, 3'b011, 7'h00, 4'b1001, 1'b0);
        add_vec(2'b10, 3'b000, 7'h20, 4'b0001, 1'b0);
        add_vec(2'b10, 3'b101, 7'h20, 4'b0111, 1'b0);
        add_vec(2'b10, 3'b111, 7'h20, 4'b0000, 1'b1);
        add_vec(2'b10, 3'b000, 7'h01, 4'b0000, 1'b1);
        add_vec(2'b10, 3'b010, 7'h20, 4'b0000, 1'b1);
        add_vec(2'b10, 3'b101, 7'h01, 4'b0000, 1'b1);
        add_vec(2'b11, 3'b000, 7'h20, 4'b0000, 1'b0);
        add_vec(2'b11, 3'b001, 7'h01, 4'b0000, 1'b1);
        add_vec(2'b11, 3'b001, 7'h00, 4'b0101, 1'b0);
        add_vec(2'b11, 3'b101, 7'h00, 4'b0110, 1'b0);
        add_vec(2'b11, 3'b101, 7'h20, 4'b0111, 1'b0);
        add_vec(2'b11, 3'b101, 7'h7f, 4'b0000, 1'b1);
        add_vec(2'b11, 3'b010, 7'h7f, 4'b1000, 1'b0);
        add_vec(2'b11, 3'b011, 7'h00, 4'b1001, 1'b0);
        add_vec(2'b11, 3'b100, 7'h55, 4'b0100, 1'b0);
        add_vec(2'b11, 3'b110, 7'h00, 4'b0011, 1'b0);
        add_vec(2'b11, 3'b111, 7'h20, 4'b0010, 1'b0);

        // Reset held while the inputs decode to a non-ADD, illegal value
        rst_n  = 1'b0;
        ALUOp  = 2'b10;
        funct3 = 3'b111;
        funct7 = 7'h20;
        #1;
        check("reset_async", {illegal, alu_ctrl}, 5'b0_0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", {illegal, alu_ctrl}, 5'b0_0000);

        // LW/SW with reset released: first edge captures the decode
        @(negedge clk);
        ALUOp  = 2'b00;
        funct3 = 3'b010;
        funct7 = 7'h00;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_lw", {illegal, alu_ctrl}, 5'b0_0000);
        prev_exp = 5'b0_0000;

        foreach (vecs[i]) begin
            @(negedge clk);
            ALUOp  = vecs[i].op;
            funct3 = vecs[i].f3;
            funct7 = vecs[i].f7;
            #1;
            check($sformatf("hold_%0d", i), {illegal, alu_ctrl}, prev_exp);
            @(posedge clk);
            #1;
            check($sformatf("vec_%0d op=%b f3=%b f7=%h", i, vecs[i].op, vecs[i].f3, vecs[i].f7),
                  {illegal, alu_ctrl}, {vecs[i].ill, vecs[i].ctrl});
            $display("vec %0d: ALUOp=%b funct3=%b funct7=%h -> alu_ctrl=%b illegal=%b",
                     i, vecs[i].op, vecs[i].f3, vecs[i].f7, alu_ctrl, illegal);
            prev_exp = {vecs[i].ill, vecs[i].ctrl};
        end

        // Mid-cycle reset while alu_ctrl holds SRA
        @(negedge clk);
        ALUOp  = 2'b10;
        funct3 = 3'b101;
        funct7 = 7'h20;
        @(posedge clk);
        #1;
        check("sra_before_reset", {illegal, alu_ctrl}, 5'b0_0111);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_sra", {illegal, alu_ctrl}, 5'b0_0000);
        @(posedge clk);
        #1;
        check("reset_overrides_capture", {illegal, alu_ctrl}, 5'b0_0000);

        // Mid-cycle reset clears a set illegal flag
        @(negedge clk);
        rst_n  = 1'b1;
        ALUOp  = 2'b10;
        funct3 = 3'b111;
        funct7 = 7'h20;
        @(posedge clk);
        #1;
        check("illegal_before_reset", {illegal, alu_ctrl}, 5'b1_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_illegal", {illegal, alu_ctrl}, 5'b0_0000);

        // Release and confirm the very next edge captures again
        @(negedge clk);
        rst_n  = 1'b1;
        ALUOp  = 2'b11;
        funct3 = 3'b011;
        funct7 = 7'h00;
        @(posedge clk);
        #1;
        check("post_reset_capture", {illegal, alu_ctrl}, 5'b0_1001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
